// File: rtl/stream_comp_scheduler.sv
// CFDF three-mode actor scheduler: SETUP -> CHECK -> FIRE -> WAIT_FC per mode.
// Optional WAIT_FC watchdog (ERROR state) enabled by defining SCHED_TIMEOUT_EN.
module stream_comp_scheduler #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 enable,
    input  logic                 FC,
    output logic                 invoke,
    output logic [1:0]           next_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] iter_count
);

    localparam logic [1:0] MODE_ONE   = 2'b00;
    localparam logic [1:0] MODE_THREE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CHECK, S_FIRE, S_WAIT_FC, S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           next_mode_q, next_mode_d;
    logic [CNT_WIDTH-1:0] iter_count_q, iter_count_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 invoke_q, invoke_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 halt_req;
    logic                 timed_out;

    assign halt_req = stop | stop_pending_q;

`ifdef SCHED_TIMEOUT_EN
    // Counter only has to reach TIMEOUT-2; TIMEOUT must be >= 2.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt_q, cnt_d;

    assign timed_out = (cnt_q == TW'(TIMEOUT - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_WAIT_FC && state_d == S_WAIT_FC)
            cnt_d = '0;
        else if (state_q == S_WAIT_FC && !FC)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            next_mode_q    <= MODE_ONE;
            iter_count_q   <= '0;
            stop_pending_q <= 1'b0;
            invoke_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_mode_q    <= next_mode_d;
            iter_count_q   <= iter_count_d;
            stop_pending_q <= stop_pending_d;
            invoke_q       <= invoke_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_SETUP;
            S_SETUP:   state_d = S_CHECK;
            S_CHECK: begin
                if (enable)        state_d = S_FIRE;
                else if (halt_req) state_d = S_IDLE;
            end
            S_FIRE:    state_d = S_WAIT_FC;
            S_WAIT_FC: begin
                if (FC) begin
                    if (next_mode_q == MODE_THREE && halt_req)
                        state_d = S_IDLE;
                    else
                        state_d = S_SETUP;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR:   if (start) state_d = S_SETUP;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        next_mode_d    = next_mode_q;
        iter_count_d   = iter_count_q;
        stop_pending_d = stop_pending_q;
        done_d         = 1'b0;
        if ((state_q == S_IDLE || state_q == S_ERROR) && start) begin
            next_mode_d    = MODE_ONE;
            stop_pending_d = 1'b0;
        end
        if (stop && (state_q == S_SETUP || state_q == S_FIRE ||
                     state_q == S_WAIT_FC))
            stop_pending_d = 1'b1;
        if (state_q == S_WAIT_FC && FC) begin
            if (next_mode_q == MODE_THREE) begin
                iter_count_d = iter_count_q + 1'b1;
                done_d       = 1'b1;
                if (!halt_req) next_mode_d = MODE_ONE;
            end else begin
                next_mode_d = next_mode_q + 2'd1;
            end
        end
        invoke_d = (state_d == S_FIRE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_ERROR);
        error_d  = (state_d == S_ERROR);
    end

    assign invoke     = invoke_q;
    assign next_mode  = next_mode_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign iter_count = iter_count_q;

endmodule

// File: tb/tb_stream_comp_scheduler.sv
// Directed bench for stream_comp_scheduler (CNT_WIDTH=2, TIMEOUT=8).
// Timeout checks run only when SCHED_TIMEOUT_EN is defined.
module tb_stream_comp_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       enable = 1'b0;
    logic       FC = 1'b0;
    logic       invoke;
    logic [1:0] next_mode;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] iter_count;

    int n_cmp = 0;
    int n_err = 0;

    stream_comp_scheduler #(.CNT_WIDTH(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .enable(enable), .FC(FC), .invoke(invoke),
        .next_mode(next_mode), .busy(busy), .done(done),
        .error(error), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; FC = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_invoke"}, 32'(invoke), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_mode"}, 32'(next_mode), 0);
        check({tag, "_iter"}, 32'(iter_count), 0);
    endtask

    // From just after entering SETUP: fire mode m and return FC.
    task automatic iter_step(input logic [1:0] m);
        tick();
        check("step_check_noinv", 32'(invoke), 0);
        tick();
        check("step_invoke", 32'(invoke), 1);
        check("step_mode", 32'(next_mode), 32'(m));
        tick();
        FC = 1'b1;
        tick();
        FC = 1'b0;
    endtask

    int exp_iter [5] = '{1, 2, 3, 0, 1};

    initial begin
        // Basic loop: three modes, one done, wrap to MODE_ONE
        do_reset();
        check_idle_reset("rst");
        enable = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_busy", 32'(busy), 1);
        check("a_setup_inv", 32'(invoke), 0);
        tick();
        check("a_check_inv", 32'(invoke), 0);
        tick();
        check("a_inv0", 32'(invoke), 1);
        check("a_mode0", 32'(next_mode), 0);
        tick();
        check("a_wait_inv", 32'(invoke), 0);
        FC = 1'b1;
        tick();
        FC = 1'b0;
        check("a_mode1", 32'(next_mode), 1);
        check("a_nodone", 32'(done), 0);
        iter_step(2'd1);
        check("a_mode2", 32'(next_mode), 2);
        iter_step(2'd2);
        check("a_done", 32'(done), 1);
        check("a_iter", 32'(iter_count), 1);
        check("a_loop_mode", 32'(next_mode), 0);
        check("a_loop_busy", 32'(busy), 1);
        tick();
        check("a_done_pulse", 32'(done), 0);
        tick();
        check("a_inv_loop", 32'(invoke), 1);
        check("a_mode_loop", 32'(next_mode), 0);

        // Enable stall in CHECK of MODE_TWO
        tick();
        FC = 1'b1;
        tick();
        FC = 1'b0;
        enable = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_stall_inv", 32'(invoke), 0);
            check("b_stall_busy", 32'(busy), 1);
        end
        enable = 1'b1;
        tick();
        check("b_inv", 32'(invoke), 1);
        check("b_mode", 32'(next_mode), 1);
        tick();
        FC = 1'b1;
        tick();
        FC = 1'b0;
        iter_step(2'd2);
        check("b_iter", 32'(iter_count), 2);

`ifndef SCHED_TIMEOUT_EN
        // Without the watchdog WAIT_FC waits forever
        tick();
        tick();
        check("n_inv", 32'(invoke), 1);
        repeat (20) tick();
        check("n_error", 32'(error), 0);
        check("n_busy", 32'(busy), 1);
`endif

        // Stop in WAIT_FC of MODE_ONE finishes the iteration
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("c_inv0", 32'(invoke), 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        FC = 1'b1;
        tick();
        FC = 1'b0;
        check("c_mode1", 32'(next_mode), 1);
        iter_step(2'd1);
        iter_step(2'd2);
        check("c_done", 32'(done), 1);
        check("c_iter", 32'(iter_count), 1);
        check("c_idle_busy", 32'(busy), 0);
        tick();
        check("c_done_pulse", 32'(done), 0);
        check("c_idle_mode", 32'(next_mode), 2);
        repeat (3) tick();
        check("c_hold_iter", 32'(iter_count), 1);
        check("c_hold_inv", 32'(invoke), 0);

        // Reset during FIRE drops invoke at once
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("d_inv", 32'(invoke), 1);
        #2 rst = 1'b0;
        #1;
        check("d_inv_drop", 32'(invoke), 0);
        check("d_busy_drop", 32'(busy), 0);

        // Reset during WAIT_FC of MODE_THREE, after one full iteration
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        iter_step(2'd0);
        iter_step(2'd1);
        iter_step(2'd2);
        check("e_iter1", 32'(iter_count), 1);
        iter_step(2'd0);
        iter_step(2'd1);
        tick();
        tick();
        tick();
        check("e_wait_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check_idle_reset("e_async");
        FC = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        FC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("e_no_replay_inv", 32'(invoke), 0);
            check("e_no_done", 32'(done), 0);
            check("e_no_busy", 32'(busy), 0);
            tick();
        end

        // CNT_WIDTH=2 wrap over five iterations
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iter_step(2'd0);
            iter_step(2'd1);
            iter_step(2'd2);
            check("f_done", 32'(done), 1);
            check("f_iter", 32'(iter_count), 32'(exp_iter[k]));
        end

`ifdef SCHED_TIMEOUT_EN
        // Watchdog: no FC, error 8 cycles after invoke
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t_inv", 32'(invoke), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t_error", 32'(error), (k == 8) ? 1 : 0);
            check("t_busy", 32'(busy), (k == 8) ? 0 : 1);
        end
        FC = 1'b1;
        tick();
        FC = 1'b0;
        check("t_fc_ignored", 32'(error), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t_clear", 32'(error), 0);
        check("t_restart_busy", 32'(busy), 1);
        check("t_restart_mode", 32'(next_mode), 0);
        tick();
        tick();
        check("t_reinv", 32'(invoke), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
